riscv_fetch: RTL and testbench
==============================

# riscv_fetch

Instruction fetch stage of the RV32I core. Keeps the fetch PC, issues word requests on the instruction-memory request/grant/response port, and buffers returned words with their PCs in a small in-order queue. Presents instruction and PC to decode (control decode and immediate decoding) over a valid/ready handshake. Discards stale responses on a branch/jump redirect from execute.

## Interface
- `RESET_PC`, 32'h0000_0000: PC fetched first after reset.
- `FIFO_DEPTH`, 4: instruction-queue entries (power of 2, ≥2); also the credit limit for outstanding plus buffered words.
- `i_clk`  in  1  clock; all state updates on rising edge.
- `i_rst`  in  1  reset; synchronous, active-high.
- `o_imem_req`  out  1  fetch request valid.
- `o_imem_addr`  out  `XLEN`  word address (byte address, bits [1:0] = 0).
- `i_imem_gnt`  in  1  request accepted this cycle.
- `i_imem_rvalid`  in  1  response word valid; in order, ≥1 cycle after its grant.
- `i_imem_rdata`  in  32  response word.
- `o_if_valid`  out  1  instruction available to decode.
- `o_if_instr`  out  32  instruction word; 32'h0000_0013 (NOP) when empty.
- `o_if_pc`  out  `XLEN`  PC of `o_if_instr`.
- `i_if_ready`  in  1  decode accepts; pop when `o_if_valid & i_if_ready`.
- `i_redirect`  in  1  flush and restart at `i_redirect_pc`.
- `i_redirect_pc`  in  `XLEN`  redirect target.
- `o_if_misalign`  out  1  head entry carries a misaligned-target fault (only with `RISCV_FETCH_MISALIGN_EN`).

## Operation
- State: fetch PC `pc_q`, PC-tag queue (PCs of granted, unreturned requests), instruction queue (instr+pc), `outstanding` count, `drop` count.
- Request rule: `o_imem_req = ~i_rst & ~i_redirect & (outstanding + count < FIFO_DEPTH)`, using registered counts. A pop does not free credit until the next cycle.
- `o_imem_addr = pc_q`. On `o_imem_req & i_imem_gnt`: push `pc_q` to tag queue, `pc_q += 4` (wraps at 2^XLEN), `outstanding++`.
- On `i_imem_rvalid`: pop the tag queue and decrement `outstanding`. If `drop > 0`, discard the word and decrement `drop`; else push {rdata, tag} to the instruction queue.
- Redirect cycle: `pc_q <= {i_redirect_pc[XLEN-1:2],2'b00}`. The instruction queue is flushed and `o_if_valid` is 0 next cycle. `drop <= outstanding` net of that cycle's grant and rvalid. All tags stay queued so they can be popped in order.
- Simultaneous events in a redirect cycle: a response arriving that cycle is discarded. A request granted that cycle cannot happen, because req is forced low. A pop that cycle still completes for decode.
- Push and pop in the same cycle on a full queue are legal; count is unchanged.
- Reset mid-operation clears all queues and counts. Late memory responses after reset are the memory's responsibility and must not occur.
- Reset values: `o_imem_req` 0, `o_imem_addr` RESET_PC, `o_if_valid` 0, `o_if_instr` 32'h13, `o_if_pc` 0, `o_if_misalign` 0.

## Timing
- First request is in the first cycle after `i_rst` deasserts.
- Grant at cycle N with rvalid at N+1 gives `o_if_valid` at N+2. Minimum latency grant to decode is 2 cycles.
- Redirect at cycle R: next request with the new PC at R+1. The first new instruction is at decode no earlier than R+3.
- With 1-cycle memory and `FIFO_DEPTH` 4, throughput is 1 instruction per cycle while decode is ready.
- `o_if_*` are driven from registered queue head; there is no combinational path from `i_imem_*` to `o_if_*`.

## Configuration
- `RISCV_FETCH_MISALIGN_EN` defined:
  - A redirect with `i_redirect_pc[1:0] != 0` issues no fetch.
  - It enqueues one fault entry (pc = raw target, instr = NOP, `o_if_misalign` = 1).
  - Fetching then halts (`o_imem_req` 0) until the next redirect.
- Undefined: target bits [1:0] are silently cleared and `o_if_misalign` is tied 0.

## Structure
- Shared package/`riscv_configs.v`: `XLEN`, NOP encoding constant, `RESET_PC` default.
- One sub-module, `riscv_fetch_fifo`: synchronous FIFO parameterised by width/depth with push, pop, flush, count, full, empty. It is instantiated twice (tag queue, instruction queue).

## Test plan
- Reset release, memory always granting, rvalid 1 cycle later, ready=1: requests 0x0, 0x4, 0x8…; `o_if_valid` from cycle 3 at one instruction per cycle with matching PCs.
- `i_if_ready`=0 for 10 cycles: exactly 4 requests are granted, then `o_imem_req`=0. Ready=1 drains 0x0–0xC in order, then fetching resumes at 0x10.
- Redirect to 0x100 with 2 requests outstanding: both responses dropped, next request 0x100, first decoded pc 0x100.
- Redirect in the same cycle as rvalid and a decode pop: popped instruction delivered, response discarded, queue empty next cycle.
- Grant delayed 3 cycles, rvalid delayed 5: `o_imem_addr` is held stable while req is ungranted; order and PCs are preserved.
- With `RISCV_FETCH_MISALIGN_EN`, redirect to 0x102: one entry with pc 0x102 and `o_if_misalign`=1, no request; a redirect to 0x200 resumes fetch.

Source files
------------

// File: rtl/riscv_fetch_pkg.sv
// riscv_fetch_pkg: shared configuration for the fetch stage (XLEN, NOP encoding, reset PC, queue entry).
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package riscv_fetch_pkg;

  localparam int              XLEN             = 32;
  localparam logic [31:0]     NOP_INSTR        = 32'h0000_0013;  // addi x0, x0, 0
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = '0;

  // One instruction-queue entry: word, its PC and the misaligned-target fault flag.
  typedef struct packed {
    logic            misalign;
    logic [31:0]     instr;
    logic [XLEN-1:0] pc;
  } ifq_entry_t;

  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/riscv_fetch_if.sv
// riscv_fetch_if: bundles the imem request/grant/response port, the decode valid/ready port and the redirect port.
// Latency: n/a (wires only).
// Backpressure: imem via i_imem_gnt, decode via i_if_ready.
// Modports: master = fetch stage (drives o_*), slave = memory/decode/execute side (drives i_*).
interface riscv_fetch_if;
  import riscv_fetch_pkg::*;

  logic            o_imem_req;
  logic [XLEN-1:0] o_imem_addr;
  logic            i_imem_gnt;
  logic            i_imem_rvalid;
  logic [31:0]     i_imem_rdata;
  logic            o_if_valid;
  logic [31:0]     o_if_instr;
  logic [XLEN-1:0] o_if_pc;
  logic            i_if_ready;
  logic            i_redirect;
  logic [XLEN-1:0] i_redirect_pc;
  logic            o_if_misalign;

  modport master (
    output o_imem_req, o_imem_addr, o_if_valid, o_if_instr, o_if_pc, o_if_misalign,
    input  i_imem_gnt, i_imem_rvalid, i_imem_rdata, i_if_ready, i_redirect, i_redirect_pc
  );

  modport slave (
    input  o_imem_req, o_imem_addr, o_if_valid, o_if_instr, o_if_pc, o_if_misalign,
    output i_imem_gnt, i_imem_rvalid, i_imem_rdata, i_if_ready, i_redirect, i_redirect_pc
  );

endinterface

// File: rtl/riscv_fetch_fifo.sv
// riscv_fetch_fifo: synchronous FIFO with flush; head word read straight from the storage array.
// Latency: a push is visible at the head the cycle after it is written.
// Backpressure: push is dropped when full unless a pop happens the same cycle; flush wins over push and pop.
// Ports: clk, rst (sync, active-high), push/wdata, pop/rdata, flush, count, full, empty.
module riscv_fetch_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  input  logic                     flush,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rdata   = mem[rd_ptr];

  // Storage has no reset; validity is tracked by count.
  always_ff @(posedge clk) begin
    if (do_push && !flush) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

endmodule

// File: rtl/riscv_fetch.sv
// riscv_fetch: RV32I fetch stage -- fetch PC, imem request/grant/response, in-order instruction queue to decode.
// Latency: grant to decode >= 2 cycles; redirect to first new instruction at decode >= 3 cycles.
// Backpressure: outstanding + queued words never exceed FIFO_DEPTH (credit); decode stalls with i_if_ready.
// Ports: i_clk, i_rst (sync, active-high), bus (riscv_fetch_if.master).
// Build option: RISCV_FETCH_MISALIGN_EN -- a misaligned redirect enqueues a fault entry and halts fetch.
module riscv_fetch
  import riscv_fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC   = RESET_PC_DEFAULT,
  parameter int              FIFO_DEPTH = 4
) (
  input  logic          i_clk,
  input  logic          i_rst,
  riscv_fetch_if.master bus
);
  localparam int          CW           = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW:0] CREDIT_LIMIT = (CW+1)'(FIFO_DEPTH);

  logic [XLEN-1:0] pc_q;
  logic [CW-1:0]   outstanding_q;
  logic [CW-1:0]   drop_q;

  logic            halt;
  logic            fault_push;
  logic            fire;
  logic            resp_keep;

  logic [XLEN-1:0] tag_pc;
  logic [CW-1:0]   tagq_count;
  logic            tagq_full;
  logic            tagq_empty;

  ifq_entry_t      ifq_wdata;
  ifq_entry_t      ifq_head;
  logic [CW-1:0]   ifq_count;
  logic            ifq_full;
  logic            ifq_empty;
  logic            ifq_pop;

  // Credit uses registered counts only, so a pop frees its slot one cycle later.
  assign bus.o_imem_req  = ~i_rst & ~bus.i_redirect & ~halt &
                           (({1'b0, outstanding_q} + {1'b0, ifq_count}) < CREDIT_LIMIT);
  assign bus.o_imem_addr = pc_q;
  assign fire            = bus.o_imem_req & bus.i_imem_gnt;

  // A response is kept only if it belongs to the current stream and no flush is happening.
  assign resp_keep = bus.i_imem_rvalid & (drop_q == '0) & ~bus.i_redirect;
  assign ifq_pop   = ~ifq_empty & bus.i_if_ready;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      pc_q          <= RESET_PC;
      outstanding_q <= '0;
      drop_q        <= '0;
    end else begin
      outstanding_q <= outstanding_q + CW'(fire) - CW'(bus.i_imem_rvalid);
      if (bus.i_redirect) begin
        pc_q   <= word_align(bus.i_redirect_pc);
        // Every word still in flight after this cycle is stale (no grant is possible here).
        drop_q <= outstanding_q - CW'(bus.i_imem_rvalid);
      end else begin
        if (fire) pc_q <= pc_q + XLEN'(4);
        if (bus.i_imem_rvalid && drop_q != '0) drop_q <= drop_q - 1'b1;
      end
    end
  end

`ifdef RISCV_FETCH_MISALIGN_EN
  logic            halt_q;
  logic            fault_pend_q;
  logic [XLEN-1:0] fault_pc_q;

  // The fault entry is pushed the cycle after the redirect, once the flush has emptied the queue.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      halt_q       <= 1'b0;
      fault_pend_q <= 1'b0;
      fault_pc_q   <= '0;
    end else if (bus.i_redirect) begin
      halt_q       <= |bus.i_redirect_pc[1:0];
      fault_pend_q <= |bus.i_redirect_pc[1:0];
      fault_pc_q   <= bus.i_redirect_pc;
    end else begin
      fault_pend_q <= 1'b0;
    end
  end

  assign halt       = halt_q;
  assign fault_push = fault_pend_q;

  always_comb begin
    ifq_wdata = '{misalign: 1'b0, instr: bus.i_imem_rdata, pc: tag_pc};
    if (fault_push) ifq_wdata = '{misalign: 1'b1, instr: NOP_INSTR, pc: fault_pc_q};
  end

  assign bus.o_if_misalign = ~ifq_empty & ifq_head.misalign;

  logic unused_bits;
  assign unused_bits = &{1'b0, tagq_full, tagq_empty, tagq_count, ifq_full};
`else
  assign halt       = 1'b0;
  assign fault_push = 1'b0;

  always_comb begin
    ifq_wdata = '{misalign: 1'b0, instr: bus.i_imem_rdata, pc: tag_pc};
  end

  assign bus.o_if_misalign = 1'b0;

  logic unused_bits;
  assign unused_bits = &{1'b0, tagq_full, tagq_empty, tagq_count, ifq_full,
                         ifq_head.misalign, bus.i_redirect_pc[1:0]};
`endif

  // PCs of granted, unreturned requests; never flushed so stale tags retire in order.
  riscv_fetch_fifo #(.WIDTH(XLEN), .DEPTH(FIFO_DEPTH)) u_tag_q (
    .clk   (i_clk),
    .rst   (i_rst),
    .push  (fire),
    .wdata (pc_q),
    .pop   (bus.i_imem_rvalid),
    .rdata (tag_pc),
    .flush (1'b0),
    .count (tagq_count),
    .full  (tagq_full),
    .empty (tagq_empty)
  );

  riscv_fetch_fifo #(.WIDTH($bits(ifq_entry_t)), .DEPTH(FIFO_DEPTH)) u_instr_q (
    .clk   (i_clk),
    .rst   (i_rst),
    .push  (resp_keep | fault_push),
    .wdata (ifq_wdata),
    .pop   (ifq_pop),
    .rdata (ifq_head),
    .flush (bus.i_redirect),
    .count (ifq_count),
    .full  (ifq_full),
    .empty (ifq_empty)
  );

  // Decode outputs come from registered queue state only.
  assign bus.o_if_valid = ~ifq_empty;
  assign bus.o_if_instr = ifq_empty ? NOP_INSTR : ifq_head.instr;
  assign bus.o_if_pc    = ifq_empty ? '0 : ifq_head.pc;

endmodule

// File: tb/tb_riscv_fetch.sv
// tb_riscv_fetch: directed and randomized bench for riscv_fetch against a stream-level reference model.
// Latency: n/a.
// Backpressure: memory grant/latency and decode ready are driven by the bench.
module tb_riscv_fetch;
  import riscv_fetch_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  riscv_fetch_if bus ();

  riscv_fetch #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(4)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  typedef struct {
    logic [31:0] addr;
    int          due;
  } rsp_t;

  rsp_t        pend[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          last_due = 0;
  int          ready_mode = 0;   // 0 stall, 1 always ready, 2 random
  int          gnt_mode = 0;     // 0 never, 1 always, 2 random, 3 after gnt_delay waiting cycles
  int          gnt_delay = 0;
  int          req_wait = 0;
  int          lat_min = 1;
  int          lat_max = 1;
  // Reference model: next expected request address and decoded stream position.
  logic [31:0] exp_addr = 32'h0;
  logic [31:0] exp_pc = 32'h0;
  int          mode = 0;         // 0 normal stream, 1 fault entry expected, 2 halted
  logic [31:0] fault_pc = 32'h0;
  // Statistics read by directed steps.
  int          gnt_cnt = 0;
  int          pop_cnt = 0;
  int          first_valid_cyc = -1;
  logic [31:0] first_pop_pc = 32'h0;
  logic        last_req = 1'b0;
  logic [31:0] last_addr = 32'h0;

  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    return (addr * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic clr_stats();
    gnt_cnt = 0;
    pop_cnt = 0;
    first_valid_cyc = -1;
    first_pop_pc = 32'h0;
  endtask

  // One clock cycle: drive inputs at posedge+1, decide grant at posedge+2, check, advance.
  task automatic step(input logic redir, input logic [31:0] tgt);
    logic        rv, rdy, gnt, req;
    logic [31:0] rd;
    int          d;
    rv = 1'b0;
    rd = $urandom;
    if (pend.size() > 0 && pend[0].due <= cyc) begin
      rv = 1'b1;
      rd = mem_word(pend[0].addr);
      void'(pend.pop_front());
    end
    case (ready_mode)
      0:       rdy = 1'b0;
      1:       rdy = 1'b1;
      default: rdy = 1'($urandom_range(0, 1));
    endcase
    bus.i_imem_rvalid = rv;
    bus.i_imem_rdata  = rd;
    bus.i_redirect    = redir;
    bus.i_redirect_pc = tgt;
    bus.i_if_ready    = rdy;
    bus.i_imem_gnt    = 1'b0;
    #1;
    req = bus.o_imem_req;
    gnt = 1'b0;
    if (req) begin
      case (gnt_mode)
        1:       gnt = 1'b1;
        2:       gnt = ($urandom_range(0, 2) != 0);
        3:       gnt = (req_wait >= gnt_delay);
        default: gnt = 1'b0;
      endcase
    end
    if (gnt) req_wait = 0;
    else if (req) req_wait++;
    bus.i_imem_gnt = gnt;
    last_req  = req;
    last_addr = bus.o_imem_addr;

    if (redir) chk("req_low_on_redirect", 32'(req), 0);
    else if (mode != 0) chk("req_low_when_halted", 32'(req), 0);
    if (req) chk("imem_addr", bus.o_imem_addr, exp_addr);
    if (!bus.o_if_valid) chk("empty_instr_nop", bus.o_if_instr, NOP_INSTR);
    if (mode == 2) chk("halted_queue_empty", 32'(bus.o_if_valid), 0);
`ifndef RISCV_FETCH_MISALIGN_EN
    chk("misalign_tied_low", 32'(bus.o_if_misalign), 0);
`endif
    if (bus.o_if_valid && rdy) begin
      if (first_valid_cyc < 0) begin
        first_valid_cyc = cyc;
        first_pop_pc    = bus.o_if_pc;
      end
      pop_cnt++;
      if (mode == 1) begin
        chk("fault_pc", bus.o_if_pc, fault_pc);
        chk("fault_instr", bus.o_if_instr, NOP_INSTR);
        chk("fault_flag", 32'(bus.o_if_misalign), 1);
        mode = 2;
      end else begin
        chk("decode_pc", bus.o_if_pc, exp_pc);
        chk("decode_instr", bus.o_if_instr, mem_word(exp_pc));
`ifdef RISCV_FETCH_MISALIGN_EN
        chk("decode_no_fault", 32'(bus.o_if_misalign), 0);
`endif
        exp_pc = exp_pc + 32'd4;
      end
    end

    if (gnt) begin
      gnt_cnt++;
      d = cyc + $urandom_range(lat_min, lat_max);
      if (d <= last_due) d = last_due + 1;
      pend.push_back('{addr: exp_addr, due: d});
      last_due = d;
      exp_addr = exp_addr + 32'd4;
    end
    if (redir) begin
      exp_addr = {tgt[31:2], 2'b00};
      exp_pc   = exp_addr;
      mode     = 0;
`ifdef RISCV_FETCH_MISALIGN_EN
      if (tgt[1:0] != 2'b00) begin
        mode     = 1;
        fault_pc = tgt;
      end
`endif
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Let in-flight responses return, then hold reset for two cycles and check reset outputs.
  task automatic do_reset();
    gnt_mode = 0;
    for (int i = 0; i < 60 && pend.size() > 0; i++) step(1'b0, 32'h0);
    chk("memory_quiesced", 32'(pend.size()), 0);
    pend.delete();
    rst = 1'b1;
    bus.i_imem_gnt    = 1'b0;
    bus.i_imem_rvalid = 1'b0;
    bus.i_imem_rdata  = 32'h0;
    bus.i_if_ready    = 1'b0;
    bus.i_redirect    = 1'b0;
    bus.i_redirect_pc = 32'h0;
    repeat (2) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    chk("rst_imem_req", 32'(bus.o_imem_req), 0);
    chk("rst_imem_addr", bus.o_imem_addr, 32'h0);
    chk("rst_if_valid", 32'(bus.o_if_valid), 0);
    chk("rst_if_instr", bus.o_if_instr, 32'h0000_0013);
    chk("rst_if_pc", bus.o_if_pc, 32'h0);
    chk("rst_if_misalign", 32'(bus.o_if_misalign), 0);
    exp_addr = 32'h0;
    exp_pc   = 32'h0;
    mode     = 0;
    last_due = cyc;
    req_wait = 0;
    rst      = 1'b0;
  endtask

  initial begin
    int t0;
    int rc;
    logic [31:0] tgt;

    bus.i_imem_gnt    = 1'b0;
    bus.i_imem_rvalid = 1'b0;
    bus.i_imem_rdata  = 32'h0;
    bus.i_if_ready    = 1'b0;
    bus.i_redirect    = 1'b0;
    bus.i_redirect_pc = 32'h0;
    @(posedge clk);
    #1;

    // Streaming from reset with a 1-cycle memory.
    do_reset();
    ready_mode = 1; gnt_mode = 1; lat_min = 1; lat_max = 1;
    clr_stats();
    t0 = cyc;
    step(1'b0, 32'h0);
    chk("first_req_cycle1", 32'(last_req), 1);
    chk("first_req_addr", last_addr, 32'h0);
    repeat (11) step(1'b0, 32'h0);
    chk("first_valid_cycle3", 32'(first_valid_cyc - t0), 2);
    chk("streaming_throughput", 32'(pop_cnt), 10);

    // Decode stalled: credit caps the grants at the queue depth.
    do_reset();
    ready_mode = 0; gnt_mode = 1;
    clr_stats();
    repeat (10) step(1'b0, 32'h0);
    chk("credit_grants", 32'(gnt_cnt), 4);
    chk("credit_req_low", 32'(last_req), 0);
    ready_mode = 1;
    clr_stats();
    for (int i = 0; i < 20 && pop_cnt < 5; i++) step(1'b0, 32'h0);
    chk("drain_then_resume", 32'(pop_cnt), 5);

    // Redirect with two requests outstanding.
    do_reset();
    ready_mode = 1; gnt_mode = 1; lat_min = 4; lat_max = 4;
    step(1'b0, 32'h0);
    step(1'b0, 32'h0);
    chk("two_outstanding", 32'(pend.size()), 2);
    step(1'b1, 32'h100);
    clr_stats();
    step(1'b0, 32'h0);
    chk("redirect_req_next", 32'(last_req), 1);
    chk("redirect_req_addr", last_addr, 32'h100);
    for (int i = 0; i < 30 && pop_cnt < 3; i++) step(1'b0, 32'h0);
    chk("redirect_first_pc", first_pop_pc, 32'h100);

    // Redirect in the same cycle as a response and a decode pop.
    do_reset();
    ready_mode = 1; gnt_mode = 1; lat_min = 1; lat_max = 1;
    step(1'b0, 32'h0);
    step(1'b0, 32'h0);
    clr_stats();
    rc = cyc;
    step(1'b1, 32'h200);
    chk("pop_on_redirect", 32'(pop_cnt), 1);
    chk("pop_on_redirect_pc", first_pop_pc, 32'h0);
    chk("flushed_next_cycle", 32'(bus.o_if_valid), 0);
    clr_stats();
    for (int i = 0; i < 10 && pop_cnt == 0; i++) step(1'b0, 32'h0);
    chk("redirect_to_decode", 32'(first_valid_cyc - rc), 3);
    chk("redirect_new_pc", first_pop_pc, 32'h200);

    // Slow memory: grant after 3 waiting cycles, response 5 cycles after grant.
    do_reset();
    ready_mode = 1; gnt_mode = 3; gnt_delay = 3; lat_min = 5; lat_max = 5;
    clr_stats();
    repeat (60) step(1'b0, 32'h0);
    chk("slow_mem_pops", 32'(pop_cnt), 13);

    // Misaligned redirect target, then an aligned one.
    do_reset();
    ready_mode = 1; gnt_mode = 1; lat_min = 1; lat_max = 1;
    repeat (4) step(1'b0, 32'h0);
    step(1'b1, 32'h102);
    clr_stats();
    repeat (8) step(1'b0, 32'h0);
`ifdef RISCV_FETCH_MISALIGN_EN
    chk("fault_entries", 32'(pop_cnt), 1);
    chk("fault_entry_pc", first_pop_pc, 32'h102);
    chk("halt_no_grants", 32'(gnt_cnt), 0);
`else
    chk("misaligned_cleared_pc", first_pop_pc, 32'h100);
    chk("misaligned_pops", 32'(pop_cnt), 6);
`endif
    step(1'b1, 32'h200);
    clr_stats();
    repeat (10) step(1'b0, 32'h0);
    chk("resume_pc", first_pop_pc, 32'h200);
    chk("resume_pops", 32'(pop_cnt), 8);

    // Random memory timing, decode readiness and redirects.
    do_reset();
    ready_mode = 2; gnt_mode = 2; lat_min = 1; lat_max = 4;
    clr_stats();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 31) == 0) begin
        tgt = 32'h1000 + 32'($urandom_range(0, 1023)) * 32'd4;
        if ($urandom_range(0, 3) == 0) tgt[1:0] = 2'($urandom_range(0, 3));
        step(1'b1, tgt);
      end else begin
        step(1'b0, 32'h0);
      end
    end
    chk("random_progress", 32'(pop_cnt >= 300), 1);

    // Reset after traffic clears everything.
    do_reset();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
